// File: rtl/hdl_lib_pkg.sv
// Shared helpers for the stream arbiter slice: clog2, the valid/data handshake
// beat, and the two-state stream encoding.
package hdl_lib_pkg;

    localparam int HS_DATA_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [HS_DATA_W-1:0] data;
    } hs_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < value; i++) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request searching ptr+1, ptr+2, ...
// with wrap modulo NUM_REQ (non-power-of-2 counts supported).
module rr_pick
    import hdl_lib_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [IDX_WIDTH-1:0] o_grant,
    output logic                 o_any
);

    localparam int SW = IDX_WIDTH + 1;

    logic [SW-1:0] w_pos;

    // Walk from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        o_grant = '0;
        o_any   = |i_req;
        w_pos   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_pos = {1'b0, i_ptr} + SW'(off);
            if (w_pos >= SW'(NUM_REQ)) w_pos = w_pos - SW'(NUM_REQ);
            if (i_req[w_pos[IDX_WIDTH-1:0]]) o_grant = w_pos[IDX_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter with optional burst hold, feeding one registered
// valid/data output stage shared by NUM_REQ sources.
module stream_rr_arbiter
    import hdl_lib_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int BURST_LEN  = 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [IDX_WIDTH-1:0]          out_idx,
    input  logic                          out_ready
);

    localparam int CNT_W = clog2(BURST_LEN) + 1;
    localparam logic [CNT_W:0] BL_C = (CNT_W+1)'(BURST_LEN);

    if (IDX_WIDTH != clog2(NUM_REQ)) begin : g_bad_idx_width
        $error("IDX_WIDTH must equal clog2(NUM_REQ)");
    end

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_data[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  r_ptr;
    logic [CNT_W-1:0]      r_cnt;

    logic [0:0]            w_state;
    logic                  w_load;
    logic                  w_hold;
    logic                  w_any;
    logic                  w_grant;
    logic [IDX_WIDTH-1:0]  w_rr_idx;
    logic [IDX_WIDTH-1:0]  w_sel;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_idx),
        .o_any   (w_any)
    );

    assign w_state = r_valid ? ST_STREAM : ST_IDLE;
    assign w_load  = ~r_valid | out_ready;

    // A burst can only be extended while streaming; the first grant after idle
    // always goes round-robin.
    assign w_hold  = (w_state == ST_STREAM) && in_valid[r_ptr] &&
                     (({1'b0, r_cnt} + (CNT_W+1)'(1)) < BL_C);
    assign w_sel   = w_hold ? r_ptr : w_rr_idx;
    assign w_grant = w_load & w_any & ~sys_rst;

    always_comb begin
        in_ready = '0;
        if (w_grant) in_ready[w_sel] = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_ptr   <= IDX_WIDTH'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_data[w_sel];
                r_idx   <= w_sel;
                r_ptr   <= w_sel;
                r_cnt   <= w_hold ? r_cnt + CNT_W'(1) : '0;
            end else begin
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench: two arbiters (BURST_LEN 1 and 4) share clock, reset and
// out_ready; each has its own AXI-style counting sources and reference model.
module tb_stream_rr_arbiter;
    import hdl_lib_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic           ordy    = 1'b1;
    logic [NR-1:0]  vld [2];
    logic [NR*DW-1:0] dat [2];
    logic [NR-1:0]  rdy [2];
    logic           ov  [2];
    logic [DW-1:0]  od  [2];
    logic [1:0]     oi  [2];

    stream_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_WIDTH(2), .BURST_LEN(1)) u_rr (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(vld[0]), .in_data(dat[0]),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_idx(oi[0]),
        .out_ready(ordy)
    );

    stream_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_WIDTH(2), .BURST_LEN(4)) u_burst (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(vld[1]), .in_data(dat[1]),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_idx(oi[1]),
        .out_ready(ordy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0] idx;
        hs_t        beat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int passed = 0;
    int total  = 0;
    int mode      = 2;   // 0 none, 1 only req2, 2 all valid, 3 random AXI sources
    int ordy_mode = 1;   // 0 stall, 1 always ready, 2 random
    bit run_mon   = 1'b0;

    logic [7:0]    cnt [2][NR];
    logic [NR-1:0] acc [2];
    bit            m_ov  [2];
    logic [1:0]    m_ptr [2];
    int            m_bc  [2];

    function automatic int bl(input bit k);
        return k ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input bit k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int kk = 0; kk < 2; kk++) begin
            m_ov[kk]  = 1'b0;
            m_ptr[kk] = 2'(NR - 1);
            m_bc[kk]  = 0;
            acc[kk]   = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic drive_one(input bit k);
        for (int r = 0; r < NR; r++) begin
            logic [1:0] ri;
            ri = 2'(r);
            if (acc[k][ri]) cnt[k][ri] = cnt[k][ri] + 8'd1;
            case (mode)
                0: vld[k][ri] = 1'b0;
                1: vld[k][ri] = (r == 2);
                2: vld[k][ri] = 1'b1;
                default: if (!(vld[k][ri] && !acc[k][ri])) vld[k][ri] = ($urandom_range(2) != 0);
            endcase
            dat[k][r*DW +: DW] = cnt[k][ri];
        end
    endtask

    task automatic drive_all();
        drive_one(1'b0);
        drive_one(1'b1);
        case (ordy_mode)
            0: ordy = 1'b0;
            1: ordy = 1'b1;
            default: ordy = ($urandom_range(3) != 0);
        endcase
    endtask

    // Reference: predicts the grant for the coming edge from the arbitration rules.
    task automatic model_step(input bit k);
        logic [NR-1:0] v, er;
        logic [1:0]    s, cand;
        bit            load, found;
        exp_t          e;
        v     = vld[k];
        er    = '0;
        s     = '0;
        found = 1'b0;
        load  = !m_ov[k] || ordy;
        if (load && v != '0) begin
            if (m_ov[k] && m_bc[k] < bl(k) - 1 && v[m_ptr[k]]) begin
                s = m_ptr[k];
                m_bc[k]++;
            end else begin
                for (int off = 1; off <= NR; off++) begin
                    cand = 2'(int'(m_ptr[k]) + off);
                    if (!found && v[cand]) begin
                        s = cand;
                        found = 1'b1;
                    end
                end
                m_bc[k] = 0;
            end
            er[s]        = 1'b1;
            e.idx        = s;
            e.beat.valid = 1'b1;
            e.beat.data  = dat[k][s*DW +: DW];
            if (k) q1.push_back(e);
            else   q0.push_back(e);
            m_ov[k]  = 1'b1;
            m_ptr[k] = s;
        end else if (load) begin
            m_ov[k] = 1'b0;
            m_bc[k] = 0;
        end
        chk("in_ready", k, 32'(rdy[k]), 32'(er));
        acc[k] = v & rdy[k];
    endtask

    task automatic cycle(input bit do_rst);
        @(negedge sys_clk);
        if (sys_rst) sys_rst = 1'b0;
        drive_all();
        if (do_rst) begin
            #3;
            sys_rst = 1'b1;
            #1;
            for (int kk = 0; kk < 2; kk++) begin
                chk("midrst_out_valid", 1'(kk), 32'(ov[kk]), 32'd0);
                chk("midrst_in_ready", 1'(kk), 32'(rdy[kk]), 32'd0);
            end
            model_reset();
        end else begin
            #1;
            model_step(1'b0);
            model_step(1'b1);
        end
    endtask

    task automatic mon(input bit k);
        exp_t e;
        int   depth;
        depth = k ? q1.size() : q0.size();
        if (ov[k]) begin
            if (depth == 0) begin
                chk("spurious_out_valid", k, 32'(ov[k]), 32'd0);
            end else begin
                e = k ? q1[0] : q0[0];
                chk("out_idx", k, 32'(oi[k]), 32'(e.idx));
                chk("out_data", k, 32'(od[k]), 32'(e.beat.data));
                if (ordy) begin
                    if (k) void'(q1.pop_front());
                    else   void'(q0.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            #2;
            if (run_mon && !sys_rst) begin
                mon(1'b0);
                mon(1'b1);
            end
        end
    end

    initial begin
        for (int kk = 0; kk < 2; kk++)
            for (int r = 0; r < NR; r++) cnt[kk][r] = 8'd0;
        for (int kk = 0; kk < 2; kk++) vld[kk] = '0;
        model_reset();
        mode = 2;
        drive_all();

        // Reset held with every requester valid.
        repeat (4) begin
            @(negedge sys_clk);
            #1;
            for (int kk = 0; kk < 2; kk++) begin
                chk("rst_out_valid", 1'(kk), 32'(ov[kk]), 32'd0);
                chk("rst_out_data", 1'(kk), 32'(od[kk]), 32'd0);
                chk("rst_in_ready", 1'(kk), 32'(rdy[kk]), 32'd0);
            end
        end
        #7;
        sys_rst = 1'b0;
        run_mon = 1'b1;

        mode = 1; ordy_mode = 1;
        repeat (12) cycle(1'b0);
        mode = 0;
        repeat (3) cycle(1'b0);
        mode = 2;
        repeat (16) cycle(1'b0);
        ordy_mode = 0;
        repeat (3) cycle(1'b0);
        ordy_mode = 1;
        repeat (6) cycle(1'b0);
        cycle(1'b1);
        repeat (10) cycle(1'b0);

        mode = 3; ordy_mode = 2;
        repeat (3000) cycle(1'b0);

        mode = 0; ordy_mode = 1;
        repeat (5) cycle(1'b0);
        chk("drain_queue", 1'b0, 32'(q0.size()), 32'd0);
        chk("drain_queue", 1'b1, 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
